// File: rtl/cla_word_sequencer_if.sv
// rtl/cla_word_sequencer_if.sv - request and adder-side signal bundle for cla_word_sequencer
//
// Purpose: groups the requester start/done handshake and the external cla16
// adder connection into one bundle.
//   slave modport  : the sequencer (takes requests, drives cla16 operands)
//   master modport : the environment (requester plus the cla16 instance)
// Signals:
//   start, Sub, Cin_in, A_in, B_in : request and operands, sampled with start
//   busy, done                     : status; done is a one-cycle result pulse
//   Result, Cout, Ovf              : W-bit result, final carry, signed overflow
//   add_A, add_B, add_Cin          : cla16 operand slice and carry-in
//   add_Sum, add_G, add_P          : cla16 sum and group generate/propagate
interface cla_word_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         start;
    logic         Sub;
    logic         Cin_in;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Cout;
    logic         Ovf;
    logic [15:0]  add_A;
    logic [15:0]  add_B;
    logic         add_Cin;
    logic [15:0]  add_Sum;
    logic         add_G;
    logic         add_P;

    modport slave (
        input  start, Sub, Cin_in, A_in, B_in, add_Sum, add_G, add_P,
        output busy, done, Result, Cout, Ovf, add_A, add_B, add_Cin
    );

    modport master (
        output start, Sub, Cin_in, A_in, B_in, add_Sum, add_G, add_P,
        input  busy, done, Result, Cout, Ovf, add_A, add_B, add_Cin
    );
endinterface

// File: rtl/cla_word_sequencer.sv
// rtl/cla_word_sequencer.sv - multi-word add/subtract sequencer sharing one cla16 adder
//
// Purpose: computes A+B or A-B over WORDS 16-bit slices, one slice per clock,
// through a single external cla16. The slice carry-out is rebuilt from the
// adder's G/P outputs and chained into the next slice.
// Ports:
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : slave side of cla_word_sequencer_if (request handshake, result,
//           and the cla16 operand/result connection)
module cla_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    cla_word_sequencer_if.slave  bus
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          sub_r;
    logic          c;
    logic [IW-1:0] idx;
    logic [W-1:0]  result_r;
    logic          cout_r;
    logic          ovf_r;

    logic [IW+3:0] base;
    logic [15:0]   slice_a;
    logic [15:0]   slice_b;
    logic          slice_cout;
    logic          carry_msb;
    logic          last;

    // Bit offset of the current slice is idx*16.
    assign base    = {idx, 4'b0000};
    assign slice_a = a_r[base +: 16];
    assign slice_b = b_r[base +: 16] ^ {16{sub_r}};
    assign last    = (idx == IW'(WORDS - 1));

    // Adder operands come only from registers; they are parked at zero outside RUN.
    assign bus.add_A   = (state == RUN) ? slice_a : 16'd0;
    assign bus.add_B   = (state == RUN) ? slice_b : 16'd0;
    assign bus.add_Cin = (state == RUN) ? c : 1'b0;

    // Slice carry-out from group generate/propagate and the registered carry-in.
    assign slice_cout = bus.add_G | (bus.add_P & c);
    // Carry into bit 15 recovered from the sum bit and its two operand bits.
    assign carry_msb  = bus.add_Sum[15] ^ bus.add_A[15] ^ bus.add_B[15];

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.Result = result_r;
    assign bus.Cout   = cout_r;
    assign bus.Ovf    = ovf_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            c        <= 1'b0;
            idx      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r   <= bus.A_in;
                        b_r   <= bus.B_in;
                        sub_r <= bus.Sub;
                        idx   <= '0;
                        // Subtract is A + ~B + ~borrow_in, so the borrow is inverted into a carry.
                        c     <= bus.Cin_in ^ bus.Sub;
                    end
                end
                RUN: begin
                    result_r[base +: 16] <= bus.add_Sum;
                    c                    <= slice_cout;
                    idx                  <= idx + IW'(1);
                    if (last) begin
                        cout_r <= slice_cout;
                        ovf_r  <= slice_cout ^ carry_msb;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-precision add/subtract sequencer that time-shares one external `cla16` 16-bit carry-lookahead adder. It computes WORDS×16-bit sums one 16-bit slice per clock. Each slice's carry-out, formed from the adder's G/P outputs, is chained into the next slice's carry-in. It sits between a requesting datapath, which uses a start/done handshake, and the single `cla16` instance it drives.

## Interface
Parameters:
- `WORDS`, default 4: number of 16-bit slices. Range 2–16. Operand width W = 16×WORDS.

Ports:
- `Clk`  in  1  rising-edge clock
- `Reset`  in  1  synchronous, active-high reset
- `start`  in  1  request. Sampled only in IDLE.
- `Sub`  in  1  0 = A+B, 1 = A−B. Sampled with `start`.
- `Cin_in`  in  1  carry-in (add) or borrow-in (sub). Sampled with `start`.
- `A_in`  in  W  operand A. Sampled with `start`.
- `B_in`  in  W  operand B. Sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `Result`  out  W  sum or difference. Held until the next accepted `start`.
- `Cout`  out  1  final carry. In Sub mode, 1 = no borrow.
- `Ovf`  out  1  signed (two's-complement) overflow of the W-bit result.
- `add_A`  out  16  to `cla16` A
- `add_B`  out  16  to `cla16` B. Already inverted when `Sub`=1.
- `add_Cin`  out  1  to `cla16` Cin
- `add_Sum`  in  16  from `cla16` Sum
- `add_G`  in  1  from `cla16` G
- `add_P`  in  1  from `cla16` P

## Operation
- FSM states: IDLE, RUN, DONE. Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→DONE when slice index `idx` = WORDS−1 is captured.
  - DONE→IDLE unconditionally.
- On accept:
  - Latch A, B and Sub.
  - Set `idx`=0.
  - Set carry register `c` = `Cin_in` if Sub=0; `c` = ~`Cin_in` if Sub=1. Thus Sub with `Cin_in`=0 computes A+~B+1.
- In RUN, the adder inputs are combinational from registers only:
  - `add_A` = A[16·idx +: 16]
  - `add_B` = B slice, XORed with {16{Sub}}
  - `add_Cin` = `c`
- In IDLE and DONE, `add_A`, `add_B` and `add_Cin` are driven to 0.
- Each RUN edge does the following:
  - Result[16·idx +: 16] ← `add_Sum`
  - `c` ← `add_G` | (`add_P` & `c`)
  - `idx` ← `idx`+1
- On the last slice's edge:
  - `Cout` ← `add_G` | (`add_P` & `c`)
  - `Ovf` ← that same carry-out XOR carry-into-MSB. Carry-into-MSB = `add_Sum`[15] ^ `add_A`[15] ^ `add_B`[15].
- Arithmetic is modulo 2^W. No saturation.
- `start` in RUN or DONE is ignored and not queued. Operand changes after accept have no effect.
- `Result`, `Cout` and `Ovf` update only during RUN. They stay stable from the DONE cycle until the next accepted request reaches its respective slice edge.

## Timing
- `start` sampled at edge E0. Slices are captured at edges E1…E_WORDS. `done`=1 and `busy`=1 for the single cycle after E_WORDS. At E_WORDS+1 the FSM returns to IDLE.
- Latency from the accept edge to `done` high: WORDS cycles. Minimum request spacing: WORDS+2 cycles.
- The `cla16` path must settle within one `Clk` period: registered slice → `cla16` → `Result`/`c`.
- `Reset` wins over every other input on any edge, including mid-RUN. It forces:
  - state=IDLE, `idx`=0, `c`=0
  - `busy`=0, `done`=0
  - `Result`=0, `Cout`=0, `Ovf`=0
  - `add_A`=0, `add_B`=0, `add_Cin`=0
- `start` asserted together with `Reset` is dropped. A request interrupted by `Reset` produces no `done`.
- `done` is never high for two consecutive cycles.

## Test plan
All scenarios use WORDS=4, with a behavioural `cla16` model attached.
- Reset: hold `Reset` 2 cycles → all outputs 0, `busy`=0. Then start 0x0001_0002_0003_0004 + 0x0010_0020_0030_0040, Sub=0, Cin_in=0 → `done` exactly 4 cycles after the accept edge; Result=0x0011_0022_0033_0044, Cout=0, Ovf=0.
- Full carry ripple: 0xFFFF_FFFF_FFFF_FFFF + 0x0000_0000_0000_0001 → Result=0, Cout=1, Ovf=0. Also `add_Cin`=1 for slices 1–3.
- Subtract with borrow across words: 0x0000_0000_0001_0000 − 0x0000_0000_0000_0001, Sub=1, Cin_in=0 → Result=0x0000_0000_0000_FFFF, Cout=1. Then 0 − 1 → Result=0xFFFF_FFFF_FFFF_FFFF, Cout=0.
- Signed overflow and carry-in: 0x7FFF_FFFF_FFFF_FFFF + 0, Cin_in=1 → Result=0x8000_0000_0000_0000, Ovf=1, Cout=0.
- Busy/reset handling:
  - Pulse `start` with new operands during RUN and again during DONE → ignored. The first result is unchanged and exactly one `done` pulse occurs.
  - Assert `Reset` at slice edge E2 of a request → no `done`, all outputs 0.
  - The next request after reset completes correctly.
- Random: 200 random A/B/Sub/Cin_in requests with random idle gaps. Each Result/Cout/Ovf is checked against a W+1-bit reference computation.
